// File: rtl/expansion_shiftreg_target.sv
// Serial expansion-port target: receives a WIDTH-bit frame from an external master
// while returning a parallel word MSB first, with framing checks and idle resync.
//
// state   | meaning
// SHIFT   | fewer than WIDTH bits received
// FULL    | exactly WIDTH bits received, LOAD will accept
// OVERRUN | more than WIDTH bits received, LOAD will reject
module expansion_shiftreg_target #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SHIFT_CLK,
  input  logic             SHIFT_LOAD,
  input  logic             SHIFT_OUT,
  output logic             SHIFT_IN,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             frame_valid,
  output logic             frame_error
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_SHIFT, ST_FULL, ST_OVERRUN} state_t;

  state_t state, state_d;

  logic [2:0]       sclk_q, sload_q;
  logic [1:0]       sout_q;
  logic [WIDTH-1:0] rx, tx;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idle_cnt;

  logic clk_rise, clk_fall, load_rise, load_fall, any_edge;
  logic timeout_hit, reload, shift_en, tx_en;

  // stage [1] is the synchronized level, stage [2] the previous level for edge detect
  assign clk_rise  =  sclk_q[1] & ~sclk_q[2];
  assign clk_fall  = ~sclk_q[1] &  sclk_q[2];
  assign load_rise =  sload_q[1] & ~sload_q[2];
  assign load_fall = ~sload_q[1] &  sload_q[2];
  assign any_edge  = clk_rise | clk_fall | load_rise | load_fall;

  assign timeout_hit = ~any_edge && (idle_cnt == IW'(TIMEOUT - 1));
  assign reload      = load_rise | (timeout_hit && (count != '0));
  assign shift_en    = clk_rise & ~load_rise;
  assign tx_en       = clk_fall & ~load_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      sload_q <= '0;
      sout_q  <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], SHIFT_CLK};
      sload_q <= {sload_q[1:0], SHIFT_LOAD};
      sout_q  <= {sout_q[0], SHIFT_OUT};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SHIFT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (reload) begin
      state_d = ST_SHIFT;
    end else if (shift_en) begin
      case (state)
        ST_SHIFT:   if (count == CW'(WIDTH - 1)) state_d = ST_FULL;
        ST_FULL:    state_d = ST_OVERRUN;
        ST_OVERRUN: state_d = ST_OVERRUN;
        default:    state_d = ST_SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx          <= '0;
      tx          <= '0;
      count       <= '0;
      SHIFT_IN    <= 1'b0;
      data_in     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= load_rise && (state == ST_FULL);
      frame_error <= (load_rise && (state != ST_FULL)) || (timeout_hit && (count != '0));
      if (load_rise && (state == ST_FULL)) data_in <= rx;
      if (reload) begin
        tx       <= data_out;
        SHIFT_IN <= data_out[WIDTH-1];
        count    <= '0;
        rx       <= '0;
      end else begin
        if (shift_en) begin
          rx <= {rx[WIDTH-2:0], sout_q[1]};
          if (count != CW'(WIDTH + 1)) count <= count + 1'b1;
        end
        if (tx_en) begin
          tx       <= {tx[WIDTH-2:0], 1'b0};
          SHIFT_IN <= tx[WIDTH-2];
        end
      end
    end
  end

  // saturates so a stalled master produces only one timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idle_cnt <= '0;
    else if (any_edge)                  idle_cnt <= '0;
    else if (idle_cnt != IW'(TIMEOUT))  idle_cnt <= idle_cnt + 1'b1;
  end

endmodule

// File: doc/expansion_shiftreg_target.md
EXPANSION_SHIFTREG_TARGET -- requirements
Module: expansion_shiftreg_target

Interface
REQ-001: Parameter WIDTH, default 8, frame length in bits (2..128).
REQ-002: Parameter TIMEOUT, default 1000000, idle clk cycles before frame resync (>= 16).
REQ-003: clk  input  1  system clock; all logic on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: SHIFT_CLK  input  1  shift clock from external expansion master, asynchronous to clk.
REQ-006: SHIFT_LOAD  input  1  frame latch strobe from master, asynchronous.
REQ-007: SHIFT_OUT  input  1  serial data from master (master-to-target), asynchronous.
REQ-008: SHIFT_IN  output  1  serial data to master (target-to-master), registered.
REQ-009: data_out  input  WIDTH  parallel word to send to master.
REQ-010: data_in  output  WIDTH  last valid word received from master, registered.
REQ-011: frame_valid  output  1  one-clk pulse when data_in updates.
REQ-012: frame_error  output  1  one-clk pulse on malformed frame or timeout.

Function
REQ-013: SHIFT_CLK, SHIFT_LOAD, SHIFT_OUT each pass a 2-flop synchronizer; edges are detected on a third registered stage.
REQ-014: Each master phase (CLK high, CLK low, LOAD high, LOAD low) lasts >= 4 clk cycles; shorter phases are out of scope.
REQ-015: Internal registers: rx shift register (WIDTH), tx shift register (WIDTH), bit counter (0..WIDTH+1, saturating), idle counter, state.
REQ-016: States: SHIFT (count < WIDTH), FULL (count == WIDTH), OVERRUN (count > WIDTH).
REQ-017: On synced SHIFT_CLK rising edge: rx <= {rx[WIDTH-2:0], synced SHIFT_OUT}; count increments, saturating at WIDTH+1; SHIFT -> FULL at WIDTH, FULL -> OVERRUN on next edge.
REQ-018: On synced SHIFT_CLK falling edge: tx shifts left one bit, zero fill; SHIFT_IN <= new tx[WIDTH-1].
REQ-019: SHIFT_IN therefore holds bit k (MSB first) from before the k-th rising edge until after the k-th falling edge at the master.
REQ-020: On synced SHIFT_LOAD rising edge in FULL: data_in <= rx, frame_valid pulses the next cycle.
REQ-021: On synced SHIFT_LOAD rising edge in SHIFT or OVERRUN: data_in unchanged, frame_error pulses, no frame_valid.
REQ-022: On any synced SHIFT_LOAD rising edge: tx <= data_out, SHIFT_IN <= data_out[WIDTH-1], count <= 0, rx <= 0, state -> SHIFT.
REQ-023: SHIFT_LOAD edge and SHIFT_CLK edge detected in the same cycle: LOAD processed, CLK edge discarded.
REQ-024: Idle counter clears on any synced edge of SHIFT_CLK or SHIFT_LOAD, else increments, saturating at TIMEOUT.
REQ-025: Idle counter reaching TIMEOUT with count != 0: frame_error pulses once, same reload action as REQ-022 but data_in unchanged.
REQ-026: Idle timeout with count == 0: no pulse, no action.
REQ-027: data_out sampled only at LOAD edge or timeout reload; changes between reloads do not affect SHIFT_IN.
REQ-028: frame_valid and frame_error never assert in the same cycle.

Reset
REQ-029: rst_n low asynchronously clears: synchronizers, rx, tx, count, idle counter, data_in = 0, SHIFT_IN = 0, frame_valid = 0, frame_error = 0, state = SHIFT.
REQ-030: First frame after reset transmits all zeros; first LOAD edge after reset loads data_out.
REQ-031: Reset asserted mid-frame discards partial rx; no pulse on release.
REQ-032: After rst_n deassertion, edges are acted on no earlier than the 3rd clk cycle (synchronizer fill).

Verification
REQ-033: WIDTH=8, master sends 0xA5 with 8 clocks + LOAD, data_out=0x3C -> data_in=0xA5, one frame_valid pulse; next frame master reads 0x3C MSB first.
REQ-034: 7 clocks then LOAD -> frame_error pulse, data_in retains prior value, count back to 0, next 8-bit frame received correctly.
REQ-035: 9 clocks then LOAD -> state OVERRUN, frame_error pulse, data_in unchanged.
REQ-036: 3 clocks then idle TIMEOUT cycles -> single frame_error pulse, then full frame 0xFF + LOAD -> data_in=0xFF.
REQ-037: rst_n pulsed low after 4 bits -> all outputs 0 immediately; following 8-bit frame 0x81 + LOAD -> data_in=0x81.
REQ-038: Minimum 4-cycle phases, back-to-back frames with random data_out/SHIFT_OUT -> scoreboard match on both directions for 1000 frames.
